// File: rtl/game_fsm_multi_if.sv
// ---------------------------------------------------------------------------
// game_fsm_multi_if
// Bundles the match-control signals exchanged between the game core and the
// match FSM.
//   master : drives start/hold/score/scorer, observes state, scores, serve,
//            winner (ball/collision logic, button debouncer, testbench)
//   slave  : the match FSM itself
// Signals
//   start      button level, may be held for many cycles
//   hold       freeze request
//   score      one-cycle scoring event
//   scorer     index of the player credited by score
//   cur_state  0=IDLE 1=PLAY 2=POINT 3=OVER
//   scores     packed scores, player i at [i*SCORE_W +: SCORE_W]
//   serve      one-cycle pulse on every entry to PLAY
//   winner     winning player, meaningful while cur_state==OVER
// ---------------------------------------------------------------------------
interface game_fsm_multi_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int IDX_W       = 3,
  parameter int SCORE_W     = 4
);
  logic                           start;
  logic                           hold;
  logic                           score;
  logic [IDX_W-1:0]               scorer;
  logic [1:0]                     cur_state;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                           serve;
  logic [IDX_W-1:0]               winner;

  modport master (
    output start, hold, score, scorer,
    input  cur_state, scores, serve, winner
  );

  modport slave (
    input  start, hold, score, scorer,
    output cur_state, scores, serve, winner
  );
endinterface

// File: rtl/game_fsm_multi.sv
// ---------------------------------------------------------------------------
// game_fsm_multi
// Match-control state machine for an N-player game. Detects the start button
// edge, keeps saturating per-player scores, runs a post-point pause and
// reports the winner. Every output comes straight from a flop.
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   game_fsm_multi_if.slave (start, hold, score, scorer in;
//         cur_state, scores, serve, winner out)
// ---------------------------------------------------------------------------
module game_fsm_multi #(
  parameter int NUM_PLAYERS  = 2,
  parameter int IDX_W        = 3,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 5,
  parameter int PAUSE_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  game_fsm_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // The pause counter only ever holds PAUSE_CYCLES-1 down to 0.
  localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_LVL    = SCORE_W'(WIN_SCORE);

  state_e                         state_q,  state_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic                           serve_q,  serve_d;
  logic [IDX_W-1:0]               winner_q, winner_d;
  logic                           start_q,  start_d;
  logic [CNT_W-1:0]               cnt_q,    cnt_d;

  logic                           start_edge;
  logic                           scorer_ok;
  logic [SCORE_W-1:0]             cur_score;
  logic [SCORE_W-1:0]             new_score;

  // Next-state, next-score and output computation for the match FSM.
  always_comb begin
    state_d    = state_q;
    scores_d   = scores_q;
    serve_d    = 1'b0;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    start_d    = bus.start;
    start_edge = bus.start & ~start_q;
    scorer_ok  = (int'(bus.scorer) < NUM_PLAYERS);

    // Current score of the credited player; stays 0 for an out-of-range index.
    cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cur_score = (bus.scorer == IDX_W'(i)) ? scores_q[i*SCORE_W +: SCORE_W] : cur_score;
    end
    new_score = (cur_score == SCORE_MAX) ? SCORE_MAX : cur_score + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d  = ST_PLAY;
          scores_d = '0;
          serve_d  = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_PLAY: begin
        // A restart wins over a score arriving in the same cycle.
        if (start_edge) begin
          state_d  = ST_PLAY;
          scores_d = '0;
          serve_d  = 1'b1;
        end else if (bus.hold) begin
          state_d  = ST_PLAY;
        end else if (bus.score && scorer_ok) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            scores_d[i*SCORE_W +: SCORE_W] = (bus.scorer == IDX_W'(i)) ?
                                             new_score : scores_q[i*SCORE_W +: SCORE_W];
          end
          if (new_score >= WIN_LVL) begin
            state_d  = ST_OVER;
            winner_d = bus.scorer;
          end else begin
            state_d  = ST_POINT;
            cnt_d    = PAUSE_LOAD;
          end
        end else begin
          state_d  = ST_PLAY;
        end
      end

      ST_POINT: begin
        if (start_edge) begin
          state_d  = ST_PLAY;
          scores_d = '0;
          serve_d  = 1'b1;
        end else if (bus.hold) begin
          state_d  = ST_POINT;
        end else if (cnt_q == '0) begin
          state_d  = ST_PLAY;
          serve_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q - 1'b1;
        end
      end

      ST_OVER: begin
        // Winner stays visible until the next match starts.
        if (start_edge) begin
          state_d  = ST_PLAY;
          scores_d = '0;
          winner_d = '0;
          serve_d  = 1'b1;
        end else begin
          state_d  = ST_OVER;
        end
      end

      default: begin
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, score, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      scores_q <= '0;
      serve_q  <= 1'b0;
      winner_q <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      scores_q <= scores_d;
      serve_q  <= serve_d;
      winner_q <= winner_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cur_state = state_q;
  assign bus.scores    = scores_q;
  assign bus.serve     = serve_q;
  assign bus.winner    = winner_q;

endmodule
